regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL provide these ports:
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- a_valid  in  1  ALU write-back request
- a_ready  out  1  ALU request accepted when a_valid & a_ready at an edge
- a_reg  in  5  ALU destination register
- a_data  in  32  ALU result
- b_valid  in  1  load-unit write-back request
- b_ready  out  1  load request accepted when b_valid & b_ready at an edge
- b_reg  in  5  load destination register
- b_data  in  32  load data
- writeReg  out  5  register-file write address, registered
- writeData  out  32  register-file write data, registered
- RegWrite  out  1  register-file write enable, registered, one-cycle pulse per write
- idle  out  1  high when both buffers are empty and RegWrite is low
REQ-002 There SHALL be one clock, clk; reset SHALL be synchronous and active-low.

Function
REQ-003 Each requester SHALL own a 1-entry buffer holding reg, data and an age tag.
REQ-004 a_ready SHALL equal (A buffer empty) OR (A buffer granted this cycle); b_ready likewise for B.
REQ-005 While reset is low, a_ready and b_ready SHALL be 0.
REQ-006 An accepted request SHALL load its buffer at the accepting edge; a same-edge drain and refill SHALL be legal.
REQ-007 Each cycle with at least one full buffer, exactly one buffer SHALL be granted, combinationally.
REQ-008 With both buffers full and different registers, the grant SHALL alternate round-robin; the pointer SHALL flip only on a contested grant.
REQ-009 With both buffers full and the same register, the older entry SHALL be granted first. On same-edge acceptance, A SHALL count as older.
REQ-010 The granted entry SHALL drive writeReg/writeData with RegWrite=1 at the next edge. Latency SHALL be 2 edges from acceptance to RegWrite high.
REQ-011 When no buffer is granted, RegWrite SHALL be 0 at the next edge, and writeReg/writeData SHALL hold their previous values.
REQ-012 Sustained throughput SHALL be one register-file write per cycle.
REQ-013 A waiting full buffer SHALL be granted within 2 cycles.
REQ-014 The block SHALL never drop or duplicate an accepted request, except on reset.
REQ-015 Data SHALL be passed unmodified at 32 bits; writeReg SHALL be passed unmodified at 5 bits.

Reset
REQ-016 On a clock edge with reset low, the block SHALL:
- clear both buffers, discarding any pending requests
- set RegWrite=0, writeReg=0, writeData=0
- set the round-robin pointer to favour A next
- clear the age tags
REQ-017 The idle output SHALL be 1 in the cycle after reset is applied.
REQ-018 Reset asserted mid-operation SHALL take priority over acceptance and grant in that cycle.
REQ-019 No RegWrite pulse SHALL be produced for requests pending at reset.

Configuration
REQ-020 The block SHALL support the macro REGFILE_WB_ZERO_GUARD_EN.
REQ-021 With REGFILE_WB_ZERO_GUARD_EN defined, a granted entry with reg==0 SHALL be consumed with RegWrite=0, and writeReg/writeData SHALL hold.
REQ-022 Without REGFILE_WB_ZERO_GUARD_EN, writes to register 0 SHALL pass through like any other register.
REQ-023 Handshake, arbitration and age behaviour SHALL be identical in both builds.

Verification
REQ-024 Reset low for 2 edges, then high -> RegWrite=0, writeReg=0, writeData=0, idle=1, a_ready=b_ready=1.
REQ-025 Single A request (reg=1, data=35) -> 2 edges later, one cycle of RegWrite=1 with writeReg=1, writeData=35; idle=1 afterwards.
REQ-026 Same-edge A (reg=3, data=10) and B (reg=4, data=20) -> consecutive writes of 3/10 then 4/20. Repeating the pair -> B first, then A (round-robin).
REQ-027 Same-edge A (reg=5, data=1) and B (reg=5, data=2) -> write 5/1 first, then 5/2; final regfile value of r5 = 2.
REQ-028 Continuous A and B valid for 10 cycles -> 10 back-to-back RegWrite pulses, interleaved, none lost. Reset asserted mid-stream -> no further pulses and idle=1 after release.
REQ-029 A request reg=0, data=69 -> RegWrite pulse with writeReg=0 when the macro is undefined; no pulse and a_ready restored when it is defined.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Two-source register-file write-back arbiter (ALU / load), 2 edges accept->RegWrite, one write per cycle.
// Ready = buffer empty or draining this cycle; REGFILE_WB_ZERO_GUARD_EN suppresses writes to r0.
module regfile_wb_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        a_valid,
   output logic        a_ready,
   input  logic [4:0]  a_reg,
   input  logic [31:0] a_data,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [4:0]  b_reg,
   input  logic [31:0] b_data,
   output logic [4:0]  writeReg,
   output logic [31:0] writeData,
   output logic        RegWrite,
   output logic        idle
);

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
      logic [2:0]  age;
   } wbEntry_t;

   wbEntry_t    aBuf, bBuf;
   logic        aFull, bFull;
   logic [2:0]  ageCnt;
   logic        favourB;

   logic        grantA, grantB;
   logic        aAccept, bAccept;
   logic [2:0]  ageDiff;
   logic [2:0]  bTag;
   logic [4:0]  winReg;
   logic [31:0] winData;
   logic        doWrite;
   logic        zeroBlock;

   // Live entries differ in age by at most a few accepts, so the sign of the wrapped difference orders them.
   always_comb begin
      grantA  = 1'b0;
      grantB  = 1'b0;
      ageDiff = aBuf.age - bBuf.age;
      if (aFull && bFull) begin
         if (aBuf.rd == bBuf.rd)
            grantA = ageDiff[2];
         else
            grantA = !favourB;
         grantB = !grantA;
      end else begin
         grantA = aFull;
         grantB = bFull;
      end
   end

   assign a_ready = reset && (!aFull || grantA);
   assign b_ready = reset && (!bFull || grantB);
   assign aAccept = a_valid && a_ready;
   assign bAccept = b_valid && b_ready;

   // A takes the earlier tag so it counts as older on a same-edge acceptance.
   assign bTag    = ageCnt + {2'b00, aAccept};

   assign winReg  = grantA ? aBuf.rd   : bBuf.rd;
   assign winData = grantA ? aBuf.data : bBuf.data;

`ifdef REGFILE_WB_ZERO_GUARD_EN
   assign zeroBlock = (winReg == 5'd0);
`else
   assign zeroBlock = 1'b0;
`endif

   assign doWrite = (grantA || grantB) && !zeroBlock;

   always_ff @(posedge clk) begin
      if (!reset) begin
         aFull     <= 1'b0;
         bFull     <= 1'b0;
         aBuf      <= '0;
         bBuf      <= '0;
         ageCnt    <= '0;
         favourB   <= 1'b0;
         RegWrite  <= 1'b0;
         writeReg  <= '0;
         writeData <= '0;
      end else begin
         if (aAccept) begin
            aFull <= 1'b1;
            aBuf  <= '{rd: a_reg, data: a_data, age: ageCnt};
         end else if (grantA) begin
            aFull <= 1'b0;
         end

         if (bAccept) begin
            bFull <= 1'b1;
            bBuf  <= '{rd: b_reg, data: b_data, age: bTag};
         end else if (grantB) begin
            bFull <= 1'b0;
         end

         ageCnt <= ageCnt + {2'b00, aAccept} + {2'b00, bAccept};

         // Pointer only moves when both sides were competing.
         if (aFull && bFull)
            favourB <= grantA;

         RegWrite <= doWrite;
         if (doWrite) begin
            writeReg  <= winReg;
            writeData <= winData;
         end
      end
   end

   assign idle = !aFull && !bFull && !RegWrite;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed + random bench for regfile_wb_arbiter against a cycle-level behavioural model.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_valid, b_valid;
   logic        a_ready, b_ready;
   logic [4:0]  a_reg, b_reg;
   logic [31:0] a_data, b_data;
   logic [4:0]  writeReg;
   logic [31:0] writeData;
   logic        RegWrite;
   logic        idle;

   always #5 clk = ~clk;

   regfile_wb_arbiter dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
      .writeReg(writeReg), .writeData(writeData), .RegWrite(RegWrite), .idle(idle)
   );

   int compared   = 0;
   int mismatched = 0;

   // Behavioural model: two pending slots tagged with a global arrival number.
   bit  zeroGuard;
   bit  mAFull = 0, mBFull = 0;
   int  mAReg, mAData, mASeq, mBReg, mBData, mBSeq;
   int  mSeq = 0;
   bit  mFavA = 1;
   bit  mWr = 0;
   int  mWReg = 0, mWData = 0;
   int  mRf[32];
   int  oRf[32];
   int  mPulses = 0, oPulses = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int modelGrant();
      if (mAFull && mBFull) begin
         if (mAReg == mBReg) return (mASeq < mBSeq) ? 1 : 2;
         return mFavA ? 1 : 2;
      end
      if (mAFull) return 1;
      if (mBFull) return 2;
      return 0;
   endfunction

   task automatic retire(input int rd, input int dat);
      if (zeroGuard && rd == 0) begin
         mWr = 0;
      end else begin
         mWr    = 1;
         mWReg  = rd;
         mWData = dat;
         mRf[rd] = dat;
         mPulses++;
      end
   endtask

   task automatic step(input bit rst, input bit av, input int ar, input int ad,
                       input bit bv, input int br, input int bd);
      int g;
      bit aAcc, bAcc, expARdy, expBRdy, both;
      reset   = rst;
      a_valid = av; a_reg = ar[4:0]; a_data = ad;
      b_valid = bv; b_reg = br[4:0]; b_data = bd;
      #1;
      g       = modelGrant();
      expARdy = rst && (!mAFull || g == 1);
      expBRdy = rst && (!mBFull || g == 2);
      check("a_ready", a_ready, expARdy);
      check("b_ready", b_ready, expBRdy);
      aAcc = av && expARdy;
      bAcc = bv && expBRdy;
      @(posedge clk);
      if (!rst) begin
         mAFull = 0; mBFull = 0; mFavA = 1; mSeq = 0;
         mWr = 0; mWReg = 0; mWData = 0;
      end else begin
         both = mAFull && mBFull;
         mWr  = 0;
         if (g == 1) begin
            retire(mAReg, mAData);
            mAFull = 0;
            if (both) mFavA = 0;
         end else if (g == 2) begin
            retire(mBReg, mBData);
            mBFull = 0;
            if (both) mFavA = 1;
         end
         if (aAcc) begin
            mAFull = 1; mAReg = ar; mAData = ad; mASeq = mSeq; mSeq++;
         end
         if (bAcc) begin
            mBFull = 1; mBReg = br; mBData = bd; mBSeq = mSeq; mSeq++;
         end
      end
      #1;
      check("RegWrite", RegWrite, mWr);
      check("writeReg", writeReg, mWReg);
      check("writeData", writeData, mWData);
      check("idle", idle, !mAFull && !mBFull && !mWr);
      if (RegWrite === 1'b1) begin
         oRf[writeReg] = writeData;
         oPulses++;
      end
   endtask

   task automatic idleSteps(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int p0, o0;
`ifdef REGFILE_WB_ZERO_GUARD_EN
      zeroGuard = 1;
`else
      zeroGuard = 0;
`endif
      for (int i = 0; i < 32; i++) begin mRf[i] = 0; oRf[i] = 0; end
      reset = 0; a_valid = 0; b_valid = 0;
      a_reg = 0; b_reg = 0; a_data = 0; b_data = 0;
      @(posedge clk); #1;

      // Reset for two edges, then release
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      idleSteps(1);

      // Single A request
      step(1, 1, 1, 35, 0, 0, 0);
      idleSteps(3);
      check("r1_after_single", oRf[1], 35);

      // Same-edge pair, different registers, twice (round-robin)
      step(1, 1, 3, 10, 1, 4, 20);
      idleSteps(3);
      step(1, 1, 3, 11, 1, 4, 21);
      idleSteps(3);

      // Same-edge pair, same register (A older)
      step(1, 1, 5, 1, 1, 5, 2);
      idleSteps(3);
      check("r5_final", oRf[5], 2);

      // Continuous traffic for 10 cycles
      p0 = mPulses; o0 = oPulses;
      for (int i = 0; i < 10; i++)
         step(1, 1, 8 + i, $urandom, 1, 20 + i, $urandom);
      check("stream_pulses", oPulses - o0, mPulses - p0);
      // Reset mid-stream, then release
      step(0, 1, 9, 1, 1, 10, 2);
      p0 = oPulses;
      idleSteps(3);
      check("no_pulse_after_reset", oPulses - p0, 0);

      // Write to register 0
      step(1, 1, 0, 69, 0, 0, 0);
      idleSteps(3);

      // Random traffic with narrow register range for frequent collisions
      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 59) != 0), ($urandom_range(0, 9) < 7), $urandom_range(0, 3), $urandom,
              ($urandom_range(0, 9) < 7), $urandom_range(0, 3), $urandom);
      idleSteps(4);

      for (int r = 0; r < 32; r++) check($sformatf("regfile_r%0d", r), oRf[r], mRf[r]);
      check("total_pulses", oPulses, mPulses);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
